pc_fetch_unit: RTL and testbench

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

---
 rtl/pc_fetch_if.sv | 36 +++
 rtl/pc_fetch_unit.sv | 98 +++++++++
 tb/tb_pc_fetch_unit.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_if.sv
// +--------------------------------------------------------------------------+
// | pc_fetch_if : request/response bundle between the core and fetch PC unit |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

interface pc_fetch_if #(
  parameter int WIDTH = 32
) ();
  logic             stall;
  logic             fetch_ready;
  logic             redirect_valid;
  logic [WIDTH-1:0] redirect_target;
  logic             exc_req;
  logic [WIDTH-1:0] exc_pc;
  logic             eret;
  logic [WIDTH-1:0] pc;
  logic             pc_valid;
  logic [WIDTH-1:0] pc_plus_step;
  logic [WIDTH-1:0] epc;
  logic             misalign_err;

  modport master (
    output stall, fetch_ready, redirect_valid, redirect_target,
    output exc_req, exc_pc, eret,
    input  pc, pc_valid, pc_plus_step, epc, misalign_err
  );

  modport slave (
    input  stall, fetch_ready, redirect_valid, redirect_target,
    input  exc_req, exc_pc, eret,
    output pc, pc_valid, pc_plus_step, epc, misalign_err
  );
endinterface

`default_nettype wire

// File: rtl/pc_fetch_unit.sv
// +--------------------------------------------------------------------------+
// | pc_fetch_unit : fetch program counter with redirect, exception and eret  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module pc_fetch_unit #(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(32'h0000_3000),
  parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(32'h0000_4180),
  parameter int               STEP         = 4
) (
  input  logic       clk,
  input  logic       reset,
  pc_fetch_if.slave  bus
);

  typedef enum logic [1:0] {
    BOOT       = 2'd0,
    RUN        = 2'd1,
    EXC_BUBBLE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] c_step = WIDTH'(STEP);

  state_t           r_state;
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_epc;
  logic             r_pc_valid;
  logic             r_misalign_err;
  logic             w_target_aligned;
  logic             w_advance;

  assign w_target_aligned = (bus.redirect_target[1:0] == 2'b00);
  assign w_advance        = (r_state == RUN) && r_pc_valid && bus.fetch_ready && !bus.stall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= BOOT;
      r_pc           <= RESET_VECTOR;
      r_epc          <= '0;
      r_pc_valid     <= 1'b0;
      r_misalign_err <= 1'b0;
    end else begin
      r_misalign_err <= 1'b0;
      case (r_state)
        BOOT: begin
          r_state    <= RUN;
          r_pc_valid <= 1'b1;
        end
        RUN, EXC_BUBBLE: begin
          // Redirect-class requests win over stall/fetch_ready; an unaccepted pc is simply dropped.
          if (bus.exc_req) begin
            r_pc       <= EXC_VECTOR;
            r_epc      <= bus.exc_pc;
            r_state    <= EXC_BUBBLE;
            r_pc_valid <= 1'b0;
          end else if (bus.eret) begin
            r_pc       <= r_epc;
            r_state    <= RUN;
            r_pc_valid <= 1'b1;
          end else if (bus.redirect_valid) begin
            if (w_target_aligned) begin
              r_pc       <= bus.redirect_target;
              r_state    <= RUN;
              r_pc_valid <= 1'b1;
            end else begin
              r_pc           <= EXC_VECTOR;
              r_epc          <= bus.redirect_target;
              r_misalign_err <= 1'b1;
              r_state        <= EXC_BUBBLE;
              r_pc_valid     <= 1'b0;
            end
          end else begin
            if (w_advance) begin
              r_pc <= r_pc + c_step;
            end
            r_state    <= RUN;
            r_pc_valid <= 1'b1;
          end
        end
        default: begin
          r_state    <= BOOT;
          r_pc_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pc           = r_pc;
  assign bus.pc_valid     = r_pc_valid;
  assign bus.pc_plus_step = r_pc + c_step;
  assign bus.epc          = r_epc;
  assign bus.misalign_err = r_misalign_err;

endmodule

`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
// +--------------------------------------------------------------------------+
// | tb_pc_fetch_unit : directed self-checking bench for pc_fetch_unit        |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_pc_fetch_unit;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  pc_fetch_if #(.WIDTH(32)) bus ();

  pc_fetch_unit #(
    .WIDTH        (32),
    .RESET_VECTOR (32'h0000_3000),
    .EXC_VECTOR   (32'h0000_4180),
    .STEP         (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.stall           = 1'b0;
    bus.fetch_ready     = 1'b1;
    bus.redirect_valid  = 1'b0;
    bus.redirect_target = '0;
    bus.exc_req         = 1'b0;
    bus.exc_pc          = '0;
    bus.eret            = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    clear_inputs();
    tick();
    tick();
    checks++; if (bus.pc !== 32'h0000_3000) begin errors++; $display("FAIL reset_pc got=%h exp=%h", bus.pc, 32'h0000_3000); end
    checks++; if (bus.pc_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", bus.pc_valid); end
    checks++; if (bus.epc !== 32'h0) begin errors++; $display("FAIL reset_epc got=%h exp=0", bus.epc); end
    checks++; if (bus.misalign_err !== 1'b0) begin errors++; $display("FAIL reset_misalign got=%b exp=0", bus.misalign_err); end
    reset = 1'b1;
    #1;
    checks++; if (bus.pc_valid !== 1'b0 || bus.pc !== 32'h0000_3000) begin errors++; $display("FAIL boot_cycle got valid=%b pc=%h exp valid=0 pc=00003000", bus.pc_valid, bus.pc); end
    tick();
    checks++; if (bus.pc_valid !== 1'b1 || bus.pc !== 32'h0000_3000) begin errors++; $display("FAIL run_first got valid=%b pc=%h exp valid=1 pc=00003000", bus.pc_valid, bus.pc); end
    tick();
    checks++; if (bus.pc !== 32'h0000_3004) begin errors++; $display("FAIL seq_1 got=%h exp=00003004", bus.pc); end
    tick();
    checks++; if (bus.pc !== 32'h0000_3008) begin errors++; $display("FAIL seq_2 got=%h exp=00003008", bus.pc); end
    checks++; if (bus.pc_plus_step !== 32'h0000_300C) begin errors++; $display("FAIL pc_plus_step got=%h exp=0000300c", bus.pc_plus_step); end
  endtask

  task automatic test_stall();
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (bus.pc !== 32'h0000_3008) begin errors++; $display("FAIL stall_hold[%0d] got=%h exp=00003008", i, bus.pc); end
    end
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h0000_3100;
    tick();
    checks++; if (bus.pc !== 32'h0000_3100 || bus.pc_valid !== 1'b1) begin errors++; $display("FAIL stall_redirect got pc=%h valid=%b exp pc=00003100 valid=1", bus.pc, bus.pc_valid); end
    clear_inputs();
  endtask

  task automatic test_fetch_ready();
    bus.fetch_ready = 1'b0;
    tick();
    checks++; if (bus.pc !== 32'h0000_3100) begin errors++; $display("FAIL not_ready_hold got=%h exp=00003100", bus.pc); end
    bus.fetch_ready = 1'b1;
    tick();
    checks++; if (bus.pc !== 32'h0000_3104) begin errors++; $display("FAIL ready_advance got=%h exp=00003104", bus.pc); end
  endtask

  task automatic test_simultaneous();
    bus.exc_req         = 1'b1;
    bus.exc_pc          = 32'h0000_3010;
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h0000_3200;
    bus.eret            = 1'b1;
    tick();
    checks++; if (bus.pc !== 32'h0000_4180 || bus.epc !== 32'h0000_3010) begin errors++; $display("FAIL exc_take got pc=%h epc=%h exp pc=00004180 epc=00003010", bus.pc, bus.epc); end
    checks++; if (bus.pc_valid !== 1'b0 || bus.misalign_err !== 1'b0) begin errors++; $display("FAIL exc_bubble got valid=%b mis=%b exp valid=0 mis=0", bus.pc_valid, bus.misalign_err); end
    clear_inputs();
    tick();
    checks++; if (bus.pc_valid !== 1'b1 || bus.pc !== 32'h0000_4180) begin errors++; $display("FAIL exc_resume got valid=%b pc=%h exp valid=1 pc=00004180", bus.pc_valid, bus.pc); end
    tick();
    checks++; if (bus.pc !== 32'h0000_4184) begin errors++; $display("FAIL handler_seq got=%h exp=00004184", bus.pc); end
    bus.eret  = 1'b1;
    bus.stall = 1'b1;
    tick();
    checks++; if (bus.pc !== 32'h0000_3010 || bus.epc !== 32'h0000_3010 || bus.pc_valid !== 1'b1) begin errors++; $display("FAIL eret got pc=%h epc=%h valid=%b exp pc=00003010 epc=00003010 valid=1", bus.pc, bus.epc, bus.pc_valid); end
    clear_inputs();
  endtask

  task automatic test_misaligned();
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h0000_3102;
    tick();
    checks++; if (bus.pc !== 32'h0000_4180 || bus.epc !== 32'h0000_3102) begin errors++; $display("FAIL misalign_pc got pc=%h epc=%h exp pc=00004180 epc=00003102", bus.pc, bus.epc); end
    checks++; if (bus.misalign_err !== 1'b1 || bus.pc_valid !== 1'b0) begin errors++; $display("FAIL misalign_flag got mis=%b valid=%b exp mis=1 valid=0", bus.misalign_err, bus.pc_valid); end
    clear_inputs();
    tick();
    checks++; if (bus.misalign_err !== 1'b0 || bus.pc_valid !== 1'b1 || bus.pc !== 32'h0000_4180) begin errors++; $display("FAIL misalign_after got mis=%b valid=%b pc=%h exp mis=0 valid=1 pc=00004180", bus.misalign_err, bus.pc_valid, bus.pc); end
    // eret outranks a simultaneous redirect
    bus.eret            = 1'b1;
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h0000_3300;
    tick();
    checks++; if (bus.pc !== 32'h0000_3102) begin errors++; $display("FAIL eret_prio got=%h exp=00003102", bus.pc); end
    clear_inputs();
  endtask

  task automatic test_wrap();
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'hFFFF_FFFC;
    tick();
    checks++; if (bus.pc !== 32'hFFFF_FFFC || bus.pc_plus_step !== 32'h0) begin errors++; $display("FAIL wrap_redirect got pc=%h plus=%h exp pc=fffffffc plus=00000000", bus.pc, bus.pc_plus_step); end
    clear_inputs();
    tick();
    checks++; if (bus.pc !== 32'h0 || bus.misalign_err !== 1'b0 || bus.pc_valid !== 1'b1) begin errors++; $display("FAIL wrap_advance got pc=%h mis=%b valid=%b exp pc=00000000 mis=0 valid=1", bus.pc, bus.misalign_err, bus.pc_valid); end
  endtask

  task automatic test_reset_mid_bubble();
    bus.exc_req = 1'b1;
    bus.exc_pc  = 32'h0000_5550;
    tick();
    checks++; if (bus.pc_valid !== 1'b0 || bus.epc !== 32'h0000_5550) begin errors++; $display("FAIL pre_reset_bubble got valid=%b epc=%h exp valid=0 epc=00005550", bus.pc_valid, bus.epc); end
    reset = 1'b0;
    #1;
    checks++; if (bus.pc !== 32'h0000_3000 || bus.epc !== 32'h0 || bus.pc_valid !== 1'b0) begin errors++; $display("FAIL async_reset got pc=%h epc=%h valid=%b exp pc=00003000 epc=00000000 valid=0", bus.pc, bus.epc, bus.pc_valid); end
    tick();
    // Requests presented while in BOOT must have no effect
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h0000_3300;
    reset = 1'b1;
    tick();
    checks++; if (bus.pc !== 32'h0000_3000 || bus.epc !== 32'h0 || bus.pc_valid !== 1'b1) begin errors++; $display("FAIL boot_ignore got pc=%h epc=%h valid=%b exp pc=00003000 epc=00000000 valid=1", bus.pc, bus.epc, bus.pc_valid); end
    clear_inputs();
    tick();
    checks++; if (bus.pc !== 32'h0000_3004) begin errors++; $display("FAIL post_reset_seq got=%h exp=00003004", bus.pc); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_stall();
    test_fetch_ready();
    test_simultaneous();
    test_misaligned();
    test_wrap();
    test_reset_mid_bubble();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
